// File: rtl/rob_pkg.sv
// Reorder-buffer shared definitions: entry layout and the index type that
// dispatch and the reservation station carry as ROB_num.
package rob_pkg;

   localparam int ROB_DEPTH = 64;
   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
   localparam int PREG_W    = 6;
   localparam int AREG_W    = 5;
   localparam int DATA_W    = 32;

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;

   typedef struct packed {
      logic [AREG_W-1:0] rd_arch;
      logic [PREG_W-1:0] rd_phys;
      logic [PREG_W-1:0] old_phys;
      logic              reg_write;
      logic              is_store;
      logic [DATA_W-1:0] value;
   } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// Wrap-around ROB index counter with increment and synchronous clear;
// used for both the head and tail pointers.
module rob_ptr_ctr
   import rob_pkg::*;
#(
   parameter int W = ROB_IDX_W
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_r;

   // Pointer register: clear wins over increment, wrap is the natural 2**W rollover.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         ptr_r <= W'(0);
      end else if (inc) begin
         ptr_r <= ptr_r + W'(1);
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr = ptr_r;

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation at the tail, out-of-order completion by
// ROB number from three functional units, in-order retire from the head.
module reorder_buffer
   import rob_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int PREG_W = rob_pkg::PREG_W,
   parameter int AREG_W = rob_pkg::AREG_W,
   parameter int DATA_W = rob_pkg::DATA_W
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   output logic [$clog2(DEPTH)-1:0]   alloc_rob_num,
   input  logic [AREG_W-1:0]          alloc_rd_arch,
   input  logic [PREG_W-1:0]          alloc_rd_phys,
   input  logic [PREG_W-1:0]          alloc_old_phys,
   input  logic                       alloc_reg_write,
   input  logic                       alloc_is_store,
   input  logic                       cmpl_valid_0,
   input  logic [$clog2(DEPTH)-1:0]   cmpl_rob_num_0,
   input  logic [DATA_W-1:0]          cmpl_value_0,
   input  logic                       cmpl_valid_1,
   input  logic [$clog2(DEPTH)-1:0]   cmpl_rob_num_1,
   input  logic [DATA_W-1:0]          cmpl_value_1,
   input  logic                       cmpl_valid_2,
   input  logic [$clog2(DEPTH)-1:0]   cmpl_rob_num_2,
   input  logic [DATA_W-1:0]          cmpl_value_2,
   input  logic                       retire_ready,
   output logic                       retire_valid,
   output logic [$clog2(DEPTH)-1:0]   retire_rob_num,
   output logic [AREG_W-1:0]          retire_rd_arch,
   output logic [PREG_W-1:0]          retire_rd_phys,
   output logic [PREG_W-1:0]          retire_old_phys,
   output logic [DATA_W-1:0]          retire_value,
   output logic                       retire_reg_write,
   output logic                       retire_is_store,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = IDX_W + 1;
   localparam int N_CMPL = 3;

   logic [IDX_W-1:0]  head_s;
   logic [IDX_W-1:0]  tail_s;
   logic [CNT_W-1:0]  count_r;
   logic [DEPTH-1:0]  busy_r;
   logic [DEPTH-1:0]  done_r;
   rob_entry_t        entry_r [DEPTH];

   logic              clear_s;
   logic              alloc_ready_s;
   logic              retire_valid_s;
   logic              alloc_fire_s;
   logic              retire_fire_s;
   logic [N_CMPL-1:0] cmpl_valid_s;
   logic [IDX_W-1:0]  cmpl_idx_s   [N_CMPL];
   logic [DATA_W-1:0] cmpl_value_s [N_CMPL];
   rob_entry_t        alloc_entry_s;
   rob_entry_t        head_entry_s;

   // Gather completion ports and qualify both handshakes from registered state.
   always_comb begin
      clear_s         = reset | flush;
      cmpl_valid_s    = {cmpl_valid_2, cmpl_valid_1, cmpl_valid_0};
      cmpl_idx_s[0]   = cmpl_rob_num_0;
      cmpl_idx_s[1]   = cmpl_rob_num_1;
      cmpl_idx_s[2]   = cmpl_rob_num_2;
      cmpl_value_s[0] = cmpl_value_0;
      cmpl_value_s[1] = cmpl_value_1;
      cmpl_value_s[2] = cmpl_value_2;
      alloc_ready_s   = (count_r != CNT_W'(DEPTH));
      retire_valid_s  = busy_r[head_s] & done_r[head_s];
      alloc_fire_s    = alloc_valid & alloc_ready_s;
      retire_fire_s   = retire_valid_s & retire_ready;
      alloc_entry_s   = '{rd_arch:   alloc_rd_arch,
                          rd_phys:   alloc_rd_phys,
                          old_phys:  alloc_old_phys,
                          reg_write: alloc_reg_write,
                          is_store:  alloc_is_store,
                          value:     {DATA_W{1'b0}}};
      head_entry_s    = entry_r[head_s];
   end

   rob_ptr_ctr #(.W(IDX_W)) u_head (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .inc   (retire_fire_s),
      .ptr   (head_s)
   );

   rob_ptr_ctr #(.W(IDX_W)) u_tail (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .inc   (alloc_fire_s),
      .ptr   (tail_s)
   );

   // Busy/done flags: completions first, then retire frees head, then alloc claims tail.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         busy_r <= {DEPTH{1'b0}};
         done_r <= {DEPTH{1'b0}};
      end else begin
         for (int k = 0; k < N_CMPL; k++) begin
            if (cmpl_valid_s[k] && busy_r[cmpl_idx_s[k]]) begin
               done_r[cmpl_idx_s[k]] <= 1'b1;
            end
         end
         if (retire_fire_s) begin
            busy_r[head_s] <= 1'b0;
            done_r[head_s] <= 1'b0;
         end
         if (alloc_fire_s) begin
            busy_r[tail_s] <= 1'b1;
            done_r[tail_s] <= 1'b0;
         end
      end
   end

   // Entry payload; later completion ports overwrite earlier ones on a collision.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_r[i] <= '0;
         end
      end else begin
         for (int k = 0; k < N_CMPL; k++) begin
            if (cmpl_valid_s[k] && busy_r[cmpl_idx_s[k]]) begin
               entry_r[cmpl_idx_s[k]].value <= cmpl_value_s[k];
            end
         end
         if (alloc_fire_s) begin
            entry_r[tail_s] <= alloc_entry_s;
         end
      end
   end

   // Occupancy counter; a simultaneous alloc and retire cancel out.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         count_r <= CNT_W'(0);
      end else begin
         case ({alloc_fire_s, retire_fire_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign alloc_ready      = alloc_ready_s;
   assign alloc_rob_num    = tail_s;
   assign retire_valid     = retire_valid_s;
   assign retire_rob_num   = head_s;
   assign retire_rd_arch   = head_entry_s.rd_arch;
   assign retire_rd_phys   = head_entry_s.rd_phys;
   assign retire_old_phys  = head_entry_s.old_phys;
   assign retire_value     = head_entry_s.value;
   assign retire_reg_write = head_entry_s.reg_write;
   assign retire_is_store  = head_entry_s.is_store;
   assign count            = count_r;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a random run
// against a program-order queue model of the in-flight instructions.
module tb_reorder_buffer;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        alloc_valid, alloc_ready;
   logic [5:0]  alloc_rob_num;
   logic [4:0]  alloc_rd_arch;
   logic [5:0]  alloc_rd_phys, alloc_old_phys;
   logic        alloc_reg_write, alloc_is_store;
   logic        cv   [3];
   logic [5:0]  cn   [3];
   logic [31:0] cval [3];
   logic        retire_ready, retire_valid;
   logic [5:0]  retire_rob_num;
   logic [4:0]  retire_rd_arch;
   logic [5:0]  retire_rd_phys, retire_old_phys;
   logic [31:0] retire_value;
   logic        retire_reg_write, retire_is_store;
   logic [6:0]  count;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int          rob;
      logic [4:0]  rd_arch;
      logic [5:0]  rd_phys;
      logic [5:0]  old_phys;
      logic        reg_write;
      logic        is_store;
      logic        done;
      logic [31:0] value;
   } m_ent_t;

   m_ent_t mq[$];
   int     m_tail = 0;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .reset(reset), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rob_num(alloc_rob_num),
      .alloc_rd_arch(alloc_rd_arch), .alloc_rd_phys(alloc_rd_phys), .alloc_old_phys(alloc_old_phys),
      .alloc_reg_write(alloc_reg_write), .alloc_is_store(alloc_is_store),
      .cmpl_valid_0(cv[0]), .cmpl_rob_num_0(cn[0]), .cmpl_value_0(cval[0]),
      .cmpl_valid_1(cv[1]), .cmpl_rob_num_1(cn[1]), .cmpl_value_1(cval[1]),
      .cmpl_valid_2(cv[2]), .cmpl_rob_num_2(cn[2]), .cmpl_value_2(cval[2]),
      .retire_ready(retire_ready), .retire_valid(retire_valid), .retire_rob_num(retire_rob_num),
      .retire_rd_arch(retire_rd_arch), .retire_rd_phys(retire_rd_phys), .retire_old_phys(retire_old_phys),
      .retire_value(retire_value), .retire_reg_write(retire_reg_write), .retire_is_store(retire_is_store),
      .count(count)
   );

   function automatic bit exp_rvalid();
      return (mq.size() > 0) && (mq[0].done == 1'b1);
   endfunction

   task automatic clear_inputs();
      reset = 1'b0; flush = 1'b0; alloc_valid = 1'b0; retire_ready = 1'b0;
      alloc_rd_arch = 5'd0; alloc_rd_phys = 6'd0; alloc_old_phys = 6'd0;
      alloc_reg_write = 1'b0; alloc_is_store = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cv[k] = 1'b0; cn[k] = 6'd0; cval[k] = 32'd0;
      end
   endtask

   task automatic set_alloc();
      alloc_valid     = 1'b1;
      alloc_rd_arch   = 5'($urandom_range(0, 31));
      alloc_rd_phys   = 6'($urandom_range(0, 63));
      alloc_old_phys  = 6'($urandom_range(0, 63));
      alloc_reg_write = 1'($urandom_range(0, 1));
      alloc_is_store  = 1'($urandom_range(0, 1));
   endtask

   // One clock: decide handshakes from pre-edge state, then update the model.
   task automatic step();
      bit     a_fire, r_fire;
      m_ent_t e;
      a_fire = (alloc_valid == 1'b1) && (mq.size() < DEPTH);
      r_fire = (retire_ready == 1'b1) && exp_rvalid();
      @(posedge clk);
      #1;
      if (reset || flush) begin
         mq.delete();
         m_tail = 0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (cv[k]) begin
               for (int i = 0; i < mq.size(); i++) begin
                  if (mq[i].rob == int'(cn[k])) begin
                     mq[i].done  = 1'b1;
                     mq[i].value = cval[k];
                  end
               end
            end
         end
         if (r_fire) void'(mq.pop_front());
         if (a_fire) begin
            e.rob = m_tail; e.rd_arch = alloc_rd_arch; e.rd_phys = alloc_rd_phys;
            e.old_phys = alloc_old_phys; e.reg_write = alloc_reg_write;
            e.is_store = alloc_is_store; e.done = 1'b0; e.value = 32'd0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
   endtask

   task automatic do_flush();
      clear_inputs(); flush = 1'b1; step(); clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs(); reset = 1'b1; step(); clear_inputs();
      n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); end
      n_vec++; if (alloc_rob_num !== 6'd0) begin n_err++; $display("FAIL reset_alloc_rob_num got %0d want 0", alloc_rob_num); end
      n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      n_vec++; if (retire_valid !== 1'b0) begin n_err++; $display("FAIL reset_retire_valid got %b want 0", retire_valid); end
      n_vec++; if (retire_rob_num !== 6'd0) begin n_err++; $display("FAIL reset_retire_rob_num got %0d want 0", retire_rob_num); end
   endtask

   task automatic test_single();
      set_alloc(); alloc_rd_phys = 6'd1; alloc_old_phys = 6'd33;
      n_vec++; if (alloc_rob_num !== 6'd0) begin n_err++; $display("FAIL single_rob_num got %0d want 0", alloc_rob_num); end
      step(); clear_inputs();
      n_vec++; if (count !== 7'd1) begin n_err++; $display("FAIL single_count got %0d want 1", count); end
      n_vec++; if (retire_valid !== 1'b0) begin n_err++; $display("FAIL single_not_done got %b want 0", retire_valid); end
      cv[1] = 1'b1; cn[1] = 6'd0; cval[1] = 32'hAAAA_AAAA;
      step(); clear_inputs();
      n_vec++; if (retire_valid !== 1'b1) begin n_err++; $display("FAIL single_done got %b want 1", retire_valid); end
      n_vec++; if (retire_value !== 32'hAAAA_AAAA) begin n_err++; $display("FAIL single_value got %h want aaaaaaaa", retire_value); end
      n_vec++; if (retire_old_phys !== 6'd33) begin n_err++; $display("FAIL single_old_phys got %0d want 33", retire_old_phys); end
      n_vec++; if (retire_rd_phys !== 6'd1) begin n_err++; $display("FAIL single_rd_phys got %0d want 1", retire_rd_phys); end
      retire_ready = 1'b1; step(); clear_inputs();
      n_vec++; if (count !== 7'd0 || retire_valid !== 1'b0) begin n_err++; $display("FAIL single_retired got count %0d valid %b want 0 0", count, retire_valid); end
   endtask

   task automatic test_in_order();
      do_flush();
      for (int i = 0; i < 3; i++) begin set_alloc(); step(); end
      clear_inputs();
      cv[0] = 1'b1; cn[0] = 6'd2; cval[0] = $urandom(); step(); clear_inputs();
      retire_ready = 1'b1; cv[2] = 1'b1; cn[2] = 6'd1; cval[2] = $urandom(); step(); clear_inputs();
      n_vec++; if (retire_valid !== 1'b0 || count !== 7'd3) begin n_err++; $display("FAIL inorder_blocked got valid %b count %0d want 0 3", retire_valid, count); end
      retire_ready = 1'b1; cv[1] = 1'b1; cn[1] = 6'd0; cval[1] = $urandom(); step();
      cv[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (retire_valid !== 1'b1 || retire_rob_num !== 6'(i) || retire_value !== mq[0].value) begin
            n_err++; $display("FAIL inorder_retire%0d got valid %b rob %0d value %h want 1 %0d %h", i, retire_valid, retire_rob_num, retire_value, i, mq[0].value);
         end
         step();
      end
      clear_inputs();
      n_vec++; if (count !== 7'd0) begin n_err++; $display("FAIL inorder_drained got %0d want 0", count); end
   endtask

   task automatic test_full();
      do_flush();
      for (int i = 0; i < DEPTH; i++) begin set_alloc(); step(); end
      clear_inputs();
      n_vec++; if (count !== 7'd64 || alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_state got count %0d ready %b want 64 0", count, alloc_ready); end
      set_alloc(); step(); clear_inputs();
      n_vec++; if (count !== 7'd64 || alloc_rob_num !== 6'd0) begin n_err++; $display("FAIL full_extra got count %0d rob %0d want 64 0", count, alloc_rob_num); end
      cv[0] = 1'b1; cn[0] = 6'd0; cval[0] = $urandom(); step(); clear_inputs();
      set_alloc(); retire_ready = 1'b1; step(); clear_inputs();
      n_vec++; if (count !== 7'd63 || alloc_ready !== 1'b1 || alloc_rob_num !== 6'd0 || retire_rob_num !== 6'd1) begin
         n_err++; $display("FAIL full_retire_one got count %0d ready %b rob %0d head %0d want 63 1 0 1", count, alloc_ready, alloc_rob_num, retire_rob_num);
      end
      set_alloc(); step(); clear_inputs();
      n_vec++; if (count !== 7'd64 || alloc_ready !== 1'b0 || alloc_rob_num !== 6'd1) begin n_err++; $display("FAIL full_wrap_alloc got count %0d ready %b tail %0d want 64 0 1", count, alloc_ready, alloc_rob_num); end
   endtask

   task automatic test_back_to_back();
      do_flush();
      for (int i = 0; i < 5; i++) begin set_alloc(); step(); end
      clear_inputs();
      cv[2] = 1'b1; cn[2] = 6'd0; cval[2] = $urandom(); step(); clear_inputs();
      set_alloc(); retire_ready = 1'b1; step(); clear_inputs();
      n_vec++; if (count !== 7'd5 || retire_rob_num !== 6'd1 || alloc_rob_num !== 6'd6) begin
         n_err++; $display("FAIL b2b got count %0d head %0d tail %0d want 5 1 6", count, retire_rob_num, alloc_rob_num);
      end
   endtask

   task automatic test_multi_cmpl();
      do_flush();
      for (int i = 0; i < 6; i++) begin set_alloc(); step(); end
      clear_inputs();
      for (int k = 0; k < 3; k++) begin cv[k] = 1'b1; cn[k] = 6'(k); cval[k] = $urandom(); end
      step();
      for (int k = 0; k < 3; k++) begin cn[k] = 6'(k + 3); cval[k] = $urandom(); end
      step(); clear_inputs();
      retire_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         n_vec++;
         if (retire_valid !== 1'b1 || retire_rob_num !== 6'(i) || retire_value !== mq[0].value) begin
            n_err++; $display("FAIL multi_retire%0d got valid %b rob %0d value %h want 1 %0d %h", i, retire_valid, retire_rob_num, retire_value, i, mq[0].value);
         end
         step();
      end
      clear_inputs();
      cv[0] = 1'b1; cn[0] = 6'd2; cval[0] = 32'hDEAD_BEEF; step(); clear_inputs();
      n_vec++; if (count !== 7'd0 || retire_valid !== 1'b0) begin n_err++; $display("FAIL freed_cmpl got count %0d valid %b want 0 0", count, retire_valid); end
      set_alloc(); cv[1] = 1'b1; cn[1] = 6'd6; cval[1] = 32'h1234_5678; step(); clear_inputs();
      n_vec++; if (count !== 7'd1 || retire_valid !== 1'b0) begin n_err++; $display("FAIL cmpl_before_alloc got count %0d valid %b want 1 0", count, retire_valid); end
      cv[2] = 1'b1; cn[2] = 6'd6; cval[2] = 32'h0BAD_F00D; step(); clear_inputs();
      n_vec++; if (retire_valid !== 1'b1 || retire_value !== 32'h0BAD_F00D) begin n_err++; $display("FAIL late_cmpl got valid %b value %h want 1 0badf00d", retire_valid, retire_value); end
   endtask

   task automatic test_flush();
      do_flush();
      for (int i = 0; i < 10; i++) begin set_alloc(); step(); end
      clear_inputs();
      flush = 1'b1; cv[0] = 1'b1; cn[0] = 6'd0; cval[0] = $urandom(); step(); clear_inputs();
      n_vec++; if (count !== 7'd0 || retire_valid !== 1'b0 || alloc_rob_num !== 6'd0 || alloc_ready !== 1'b1) begin
         n_err++; $display("FAIL flush got count %0d valid %b tail %0d ready %b want 0 0 0 1", count, retire_valid, alloc_rob_num, alloc_ready);
      end
      step();
      n_vec++; if (retire_valid !== 1'b0 || retire_rob_num !== 6'd0) begin n_err++; $display("FAIL flush_dropped got valid %b head %0d want 0 0", retire_valid, retire_rob_num); end
   endtask

   task automatic test_random();
      do_flush();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         clear_inputs();
         if ($urandom_range(0, 99) < ((cyc % 1000) < 500 ? 80 : 40)) set_alloc();
         retire_ready = ($urandom_range(0, 99) < ((cyc % 1000) < 500 ? 30 : 85)) ? 1'b1 : 1'b0;
         for (int k = 0; k < 3; k++) begin
            cv[k] = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) cn[k] = 6'(mq[$urandom_range(0, mq.size() - 1)].rob);
            else cn[k] = 6'($urandom_range(0, 63));
            cval[k] = $urandom();
            for (int j = 0; j < k; j++) if (cv[j] && cn[j] == cn[k]) cv[k] = 1'b0;
         end
         flush = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
         step();
         n_vec++;
         if ({alloc_ready, alloc_rob_num, count, retire_valid} !== {(mq.size() < DEPTH), 6'(m_tail), 7'(mq.size()), exp_rvalid()}) begin
            n_err++; $display("FAIL rand_status cyc %0d got ready %b tail %0d count %0d valid %b want %b %0d %0d %b",
               cyc, alloc_ready, alloc_rob_num, count, retire_valid, (mq.size() < DEPTH), m_tail, mq.size(), exp_rvalid());
         end
         if (exp_rvalid()) begin
            n_vec++;
            if ({retire_rob_num, retire_rd_arch, retire_rd_phys, retire_old_phys, retire_reg_write, retire_is_store, retire_value} !==
                {6'(mq[0].rob), mq[0].rd_arch, mq[0].rd_phys, mq[0].old_phys, mq[0].reg_write, mq[0].is_store, mq[0].value}) begin
               n_err++; $display("FAIL rand_head cyc %0d got rob %0d phys %0d old %0d value %h want %0d %0d %0d %h",
                  cyc, retire_rob_num, retire_rd_phys, retire_old_phys, retire_value, mq[0].rob, mq[0].rd_phys, mq[0].old_phys, mq[0].value);
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single();
      test_in_order();
      test_full();
      test_back_to_back();
      test_multi_cmpl();
      test_flush();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order bookkeeping for the out-of-order core. Dispatch allocates one entry per instruction, and the returned `alloc_rob_num` is the `ROB_num` carried into the ReservationStation. The three functional units report completion back by ROB number. The head entry retires in program order, one per cycle, toward the commit/free-list logic.

## Interface
- `DEPTH`, 64: entries; power of two; index width = log2(DEPTH) = 6
- `PREG_W`, 6: physical register tag width
- `AREG_W`, 5: architectural register width
- `DATA_W`, 32: result width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  synchronous clear, same effect as reset
- `alloc_valid`  in  1  dispatch requests an entry
- `alloc_ready`  out  1  entry available (not full)
- `alloc_rob_num`  out  6  tail index; valid whenever `alloc_ready`
- `alloc_rd_arch`  in  AREG_W  destination architectural reg
- `alloc_rd_phys`  in  PREG_W  new physical tag
- `alloc_old_phys`  in  PREG_W  previous mapping, freed at retire
- `alloc_reg_write`  in  1  instruction writes rd
- `alloc_is_store`  in  1  store marker
- `cmpl_valid_0..2`  in  1 each  FU k result this cycle
- `cmpl_rob_num_0..2`  in  6 each  entry completed by FU k
- `cmpl_value_0..2`  in  DATA_W each  FU k result
- `retire_ready`  in  1  commit side accepts
- `retire_valid`  out  1  head entry is allocated and done
- `retire_rob_num`  out  6  head index
- `retire_rd_arch`  out  AREG_W  head field
- `retire_rd_phys`  out  PREG_W  head field
- `retire_old_phys`  out  PREG_W  head field
- `retire_value`  out  DATA_W  head result
- `retire_reg_write`  out  1  head field
- `retire_is_store`  out  1  head field
- `count`  out  7  occupied entries, 0..64

## Operation
- State: `head`, `tail` (6-bit), `count` (7-bit). Per-entry `busy`, `done`, and the stored fields.
- Alloc fire = `alloc_valid && alloc_ready`:
  - Write the fields at `tail`; set `busy=1`, `done=0`.
  - `tail` advances by 1, with natural wrap at 63→0.
- Completion, port k: if `cmpl_valid_k` and `busy[cmpl_rob_num_k]`, set `done=1` and store `cmpl_value_k`.
  - Completion to a non-busy entry is ignored.
  - Same `rob_num` on two ports in one cycle is illegal. Port 2 beats port 1, which beats port 0.
- Retire fire = `retire_valid && retire_ready`:
  - Clear `busy[head]` and `done[head]`.
  - `head` advances by 1, with wrap.
- `retire_*` fields decode combinationally from `head`. They are don't-care when `retire_valid=0`, but must hold their last entry contents rather than X.
- `count` next = count + alloc_fire − retire_fire. Both firing in one cycle leaves `count` unchanged.
- `alloc_ready = (count != DEPTH)`. This is registered-state based: a retire in the same cycle does not free a slot for alloc when full.
- Empty (`count==0`): `retire_valid=0`.
- Priority: `reset` = `flush` > all other updates. On flush, `head=tail=count=0` and all `busy`/`done` bits clear. In-flight completions in that cycle are dropped.

## Timing
- Reset/flush values (one cycle after assertion):
  - `alloc_ready=1`, `alloc_rob_num=0`, `count=0`
  - `retire_valid=0`, `retire_rob_num=0`
- Alloc at edge N makes the entry visible to completion from edge N+1.
- No completion→retire bypass: completion written at edge M raises `retire_valid` after edge M. Earliest retire is edge M+1.
- Minimum alloc-to-retire latency: 2 cycles.
- Sustained throughput: 1 alloc and 1 retire per cycle.

## Structure
- Shared package `rob_pkg`:
  - `ROB_DEPTH`, `ROB_IDX_W`, `PREG_W`, `AREG_W`
  - typedef `rob_entry_t` containing `rd_arch`, `rd_phys`, `old_phys`, `reg_write`, `is_store`, `value`
  - typedef `rob_idx_t`
- The ReservationStation and dispatch import `rob_idx_t` from this package.
- One natural sub-module: `rob_ptr_ctr`, a wrap-around index counter with increment and clear, instantiated for `head` and `tail`.
- Entry storage stays inline.

## Test plan
- Reset, then 1 alloc (rd_phys=1, old_phys=33) → `alloc_rob_num=0`, `count=1`, `retire_valid=0`.
  - Then complete port 1 rob 0 value 0xAAAAAAAA → next cycle `retire_valid=1`, `retire_value=0xAAAAAAAA`, `retire_old_phys=33`.
- Alloc rob 0,1,2; complete 2 then 1 → no retire (head not done).
  - Then complete 0 → retires 0,1,2 on three consecutive cycles with `retire_ready=1`.
- Fill 64 entries → `alloc_ready=0`, `count=64`, extra `alloc_valid` ignored.
  - Retire one → `alloc_ready=1`, `alloc_rob_num=0` (wrap). Next alloc lands at index 0.
- Simultaneous alloc and retire at count 5 → `count` stays 5, `head` and `tail` both advance.
- All three ports complete distinct entries 3,4,5 in one cycle → all marked done.
  - Completion to a freed entry → no state change.
- `flush` with 10 entries busy and a concurrent completion → `count=0`, `retire_valid=0`, `alloc_rob_num=0` next cycle.
